// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: default geometry of the video RAM,
// the tile fetch phase within an 8-pixel tile, and the CPU access FSM state encoding.
package vram_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int DATA_W_DEF    = 8;
  localparam int COLS_LOG2_DEF = 5;

  // Pixel phase inside a tile at which the display owns the RAM port.
  localparam logic [2:0] TILE_PHASE = 3'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } cpu_state_e;

endpackage

// File: rtl/vram_slot_gen.sv
// Display slot generator: decides which cycles belong to the tile fetch and
// which VRAM word the fetch reads.
// Ports:
//   hpos_i, vpos_i  - beam position from the sync generator
//   display_on_i    - visible-area flag
//   slot_o          - display owns the RAM this cycle
//   disp_addr_o     - tile address {row, column} for the fetch
module vram_slot_gen
  import vram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int COLS_LOG2 = COLS_LOG2_DEF
) (
  input  logic [15:0]       hpos_i,
  input  logic [15:0]       vpos_i,
  input  logic              display_on_i,
  output logic              slot_o,
  output logic [ADDR_W-1:0] disp_addr_o
);

  localparam int ROW_W = ADDR_W - COLS_LOG2;

  // Beam bits outside the tile row/column fields carry no meaning here.
  logic unused_hv;
  assign unused_hv = ^{hpos_i[15:COLS_LOG2+3], vpos_i[15:ROW_W+3], vpos_i[2:0]};

  assign slot_o      = display_on_i && (hpos_i[2:0] == TILE_PHASE);
  assign disp_addr_o = {vpos_i[ROW_W+2:3], hpos_i[COLS_LOG2+2:3]};

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port synchronous video RAM between the
// display tile fetch (fixed, absolute-priority slots) and a CPU requester
// using a req/ack handshake.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   hpos, vpos, display_on     - beam state from the sync generator
//   cpu_req/we/addr/wdata      - CPU request, sampled when accepted in IDLE
//   cpu_ack, cpu_rdata         - one-cycle completion pulse and read result
//   ram_addr/we/wdata, ram_rdata - RAM port (read data one cycle after address)
//   tile_data, tile_strobe     - last fetched tile and its update pulse
//   stall_cnt                  - saturating count of CPU cycles lost to slots
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COLS_LOG2 = COLS_LOG2_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       hpos,
  input  logic [15:0]       vpos,
  input  logic              display_on,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] tile_data,
  output logic              tile_strobe,
  output logic [15:0]       stall_cnt
);

  logic              slot;
  logic [ADDR_W-1:0] disp_addr;

  cpu_state_e        state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic [15:0]       stall_q;
  logic [15:0]       stall_d;
  logic              fetch_q;
  logic              strobe_q;
  logic [DATA_W-1:0] tile_q;

  vram_slot_gen #(
    .ADDR_W    (ADDR_W),
    .COLS_LOG2 (COLS_LOG2)
  ) u_slot_gen (
    .hpos_i       (hpos),
    .vpos_i       (vpos),
    .display_on_i (display_on),
    .slot_o       (slot),
    .disp_addr_o  (disp_addr)
  );

  assign stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;

  // The display always wins the port; the CPU only drives it in GRANT when
  // no slot is active. Write data is left on the bus since ram_we gates it.
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    if (slot) begin
      ram_addr = disp_addr;
    end else if (state_q == GRANT) begin
      ram_addr = addr_q;
      ram_we   = we_q;
    end
  end

  assign ram_wdata = wdata_q;

  // CPU access FSM. A request may be accepted during a slot; the slot only
  // holds it in GRANT. ack_q is high for exactly the DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      stall_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (slot) begin
            stall_q <= stall_d;
          end else if (we_q) begin
            state_q <= DONE;
            ack_q   <= 1'b1;
          end else begin
            state_q <= RDWAIT;
          end
        end
        RDWAIT: begin
          rdata_q <= ram_rdata;
          state_q <= DONE;
          ack_q   <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Display return path: a slot at T gives RAM data at T+1, which becomes
  // visible on tile_data together with the strobe at T+2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_q  <= 1'b0;
      strobe_q <= 1'b0;
      tile_q   <= '0;
    end else begin
      fetch_q  <= slot;
      strobe_q <= fetch_q;
      if (fetch_q) begin
        tile_q <= ram_rdata;
      end
    end
  end

  assign cpu_ack     = ack_q;
  assign cpu_rdata   = rdata_q;
  assign tile_data   = tile_q;
  assign tile_strobe = strobe_q;
  assign stall_cnt   = stall_q;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one synchronous single-port video RAM between two users: the display tile fetch, which is driven by hpos/vpos/display_on from hvsync_generator, and a CPU/test requester using a req/ack handshake.
- Display fetches have absolute priority in fixed slots. The CPU is served in all other cycles.
- Sits between hvsync_generator and the tile/character renderer that drives rgb.

Parameters:
- ADDR_W, 10, VRAM address width (word address).
- DATA_W, 8, VRAM data width.
- COLS_LOG2, 5, log2 of tile columns per row (8-pixel-wide tiles).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- hpos  in  16  horizontal position from hvsync_generator
- vpos  in  16  vertical position from hvsync_generator
- display_on  in  1  visible-area flag from hvsync_generator
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; sampled with request
- cpu_addr  in  ADDR_W  CPU address; sampled with request
- cpu_wdata  in  DATA_W  CPU write data; sampled with request
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read result, valid from cpu_ack onward
- ram_addr  out  ADDR_W  VRAM address
- ram_we  out  1  VRAM write enable
- ram_wdata  out  DATA_W  VRAM write data
- ram_rdata  in  DATA_W  VRAM read data, 1-cycle latency
- tile_data  out  DATA_W  last fetched display tile
- tile_strobe  out  1  pulse when tile_data updates
- stall_cnt  out  16  saturating count of CPU cycles blocked by display slots

Behaviour:
- Display slot: slot = display_on && hpos[2:0]==0 (combinational).
- Display address: {vpos[ADDR_W-COLS_LOG2+2:3], hpos[COLS_LOG2+2:3]}. With defaults this is {vpos[7:3], hpos[7:3]}.
- RAM port mux (combinational):
  - slot: ram_addr = display address, ram_we = 0.
  - else, state == GRANT: drive the latched CPU addr/we/wdata.
  - else: ram_addr = 0, ram_we = 0.
  - ram_wdata = latched cpu_wdata at all times.
- Display return path:
  - Slot at cycle T → ram_rdata valid at T+1.
  - Sampled at the T+1 edge, so tile_data updates and tile_strobe = 1 for exactly the cycle T+2.
  - T+1 is never a slot, so a CPU access may use the RAM at T+1.
- CPU FSM states: IDLE, GRANT, RDWAIT, DONE.
  - IDLE: if cpu_req, latch we/addr/wdata → GRANT. Acceptance is allowed even during a slot.
  - GRANT, slot == 1: stay in GRANT; stall_cnt += 1, saturating at 16'hFFFF.
  - GRANT, slot == 0: RAM is driven this cycle; write → DONE, read → RDWAIT.
  - RDWAIT: capture ram_rdata into cpu_rdata → DONE.
  - DONE: cpu_ack = 1 (registered) → IDLE.
  - cpu_req is ignored outside IDLE. The requester must drop cpu_req in the cycle after ack, otherwise a new access is accepted.
- Latency with no stall:
  - Write: req seen → ack 3 cycles later (IDLE, GRANT, DONE).
  - Read: 4 cycles.
  - Each slot adds 1 cycle; the worst case is 1 extra cycle per access.
- Reset (reset == 0, any time including mid-access):
  - state = IDLE; cpu_ack = 0, cpu_rdata = 0, tile_data = 0, tile_strobe = 0, stall_cnt = 0; latched request = 0.
  - An in-flight access is dropped without ack. A write in GRANT may or may not have reached RAM.
  - A still-held cpu_req is re-accepted after release.
- During blanking (display_on = 0) there are no slots and the CPU has full bandwidth.
- hpos/vpos bits above the used ranges are ignored.

Decomposition:
- Package vram_pkg:
  - State encoding (IDLE=0, GRANT=1, RDWAIT=2, DONE=3).
  - Default ADDR_W/DATA_W/COLS_LOG2.
  - TILE_PHASE constant = 0.
- One natural sub-module: vram_slot_gen, which computes slot and the display address from hpos/vpos/display_on.
- The FSM, mux and counters stay in vram_arbiter.

Test Plan:
- Reset: hold reset = 0 for 5 cycles with cpu_req = 1 → cpu_ack = 0, stall_cnt = 0, tile_data = 0. After release, a write is accepted and cpu_ack pulses 3 cycles after the first cycle with reset = 1.
- Blanking write then read: display_on = 0; write addr 10'h155 data 8'hA5, then read 10'h155 → write ack at +3, read ack at +4 with cpu_rdata = 8'hA5, stall_cnt = 0.
- Display fetch: preload RAM addr {5'd2, 5'd3} = 8'h3C; vpos = 16, hpos = 24, display_on = 1 → ram_addr = 10'h043, ram_we = 0; tile_data = 8'h3C with tile_strobe high exactly 2 cycles later.
- Collision: CPU enters GRANT on the cycle where hpos = 32 and display_on = 1 → RAM is driven with the display address that cycle, the CPU access proceeds next cycle, ack is delayed by 1, stall_cnt = 1.
- Mid-access reset: assert reset = 0 while state = RDWAIT → no cpu_ack. After release with cpu_req held, a fresh read completes correctly.
- Saturation: force 70000 blocked GRANT cycles (continuous slots via a stubbed slot input) → stall_cnt holds at 16'hFFFF.
